pixel_delay_line: RTL

PIXEL_DELAY_LINE -- requirements
Module: pixel_delay_line

---
 rtl/pixel_delay_pkg.sv | 13 +
 rtl/dly_tap_sel.sv | 21 ++
 rtl/pixel_delay_line.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pixel_delay_pkg.sv
// Shared constants for the pixel delay line: default geometry and the
// bit positions of the {vsync, hsync, de} control lane.
package pixel_delay_pkg;

  localparam int DLY_DATA_W_DEF    = 24;
  localparam int DLY_MAX_DEPTH_DEF = 64;
  localparam int DLY_CTRL_W_DEF    = 3;

  localparam int CTRL_VS = 2;
  localparam int CTRL_HS = 1;
  localparam int CTRL_DE = 0;

endpackage

// File: rtl/dly_tap_sel.sv
// Combinational tap multiplexer: picks one word out of a packed tap array.
// Selects beyond the last tap return zero.
module dly_tap_sel #(
  parameter int W     = 8,
  parameter int N     = 2,
  parameter int SEL_W = 1
) (
  input  logic [N-1:0][W-1:0] i_taps,
  input  logic [SEL_W-1:0]    i_sel,
  output logic [W-1:0]        o_word
);

  always_comb begin
    // NOTE: default assignment first so no path leaves o_word unassigned (no latch).
    o_word = '0;
    for (int k = 0; k < N; k++) begin
      if (i_sel == SEL_W'(k)) o_word = i_taps[k];
    end
  end

endmodule

// File: rtl/pixel_delay_line.sv
// Programmable pixel delay line (0..MAX_DEPTH stages, latency cur_dly+1).
// Define PIXEL_DELAY_CTRL_EN to add a {vsync, hsync, de} lane delayed identically.
module pixel_delay_line
  import pixel_delay_pkg::*;
#(
  parameter  int DATA_W    = DLY_DATA_W_DEF,
  parameter  int MAX_DEPTH = DLY_MAX_DEPTH_DEF,
  parameter  int CTRL_W    = DLY_CTRL_W_DEF,
  localparam int DLY_W     = $clog2(MAX_DEPTH + 1)
) (
  input  logic              pixelclk,
  input  logic              rst_n,
  input  logic              i_ce,
  input  logic              i_flush,
  input  logic              i_dly_ld,
  input  logic [DLY_W-1:0]  i_dly,
  input  logic [DATA_W-1:0] i_rgb,
`ifdef PIXEL_DELAY_CTRL_EN
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic [CTRL_W-1:0] o_ctrl,
`endif
  output logic [DATA_W-1:0] o_rgb,
  output logic              o_valid,
  output logic [DLY_W-1:0]  o_dly
);

  // Fill counter must reach MAX_DEPTH+1, one more than DLY_W always covers.
  localparam int                FILL_W   = $clog2(MAX_DEPTH + 2);
  localparam logic [DLY_W-1:0]  DLY_MAX  = DLY_W'(MAX_DEPTH);
  localparam logic [DLY_W-1:0]  DLY_RST  = DLY_W'(MAX_DEPTH / 2);
  localparam logic [FILL_W-1:0] FILL_SAT = FILL_W'(MAX_DEPTH + 1);

  logic [MAX_DEPTH-1:0][DATA_W-1:0] r_rgb_stage;
  logic [MAX_DEPTH:0][DATA_W-1:0]   w_rgb_taps;
  logic [DATA_W-1:0]                w_rgb_sel;
  logic [DATA_W-1:0]                r_rgb;
  logic [DLY_W-1:0]                 r_cur_dly;
  logic [DLY_W-1:0]                 w_dly_clamped;
  logic [FILL_W-1:0]                r_fill_cnt;
  logic [FILL_W-1:0]                w_fill_nxt;
  logic                             r_valid;

  // Tap 0 is the live input (zero delay); tap k is stage[k-1].
  assign w_rgb_taps    = {r_rgb_stage, i_rgb};
  assign w_dly_clamped = (i_dly > DLY_MAX) ? DLY_MAX : i_dly;
  assign w_fill_nxt    = (r_fill_cnt == FILL_SAT) ? r_fill_cnt : r_fill_cnt + 1'b1;

  dly_tap_sel #(.W(DATA_W), .N(MAX_DEPTH + 1), .SEL_W(DLY_W)) u_rgb_sel (
    .i_taps (w_rgb_taps),
    .i_sel  (r_cur_dly),
    .o_word (w_rgb_sel)
  );

  // The delay register ignores ce and flush; only a load changes it.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n)        r_cur_dly <= DLY_RST;
    else if (i_dly_ld) r_cur_dly <= w_dly_clamped;
  end

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_cnt <= '0;
      r_valid    <= 1'b0;
    end else if (i_flush || i_dly_ld) begin
      r_fill_cnt <= '0;
      r_valid    <= 1'b0;
    end else if (i_ce) begin
      r_fill_cnt <= w_fill_nxt;
      r_valid    <= (w_fill_nxt > FILL_W'(r_cur_dly));
    end
  end

  always_ff @(posedge pixelclk or negedge rst_n) begin
    // NOTE: the stage array is reset on purpose; stale pixels must never reach o_rgb.
    if (!rst_n) begin
      r_rgb_stage <= '0;
      r_rgb       <= '0;
    end else if (i_flush) begin
      r_rgb_stage <= '0;
      r_rgb       <= '0;
    end else if (i_ce) begin
      r_rgb_stage <= w_rgb_taps[MAX_DEPTH-1:0];
      r_rgb       <= w_rgb_sel;
    end
  end

  assign o_rgb   = r_rgb;
  assign o_valid = r_valid;
  assign o_dly   = r_cur_dly;

`ifdef PIXEL_DELAY_CTRL_EN
  logic [MAX_DEPTH-1:0][CTRL_W-1:0] r_ctrl_stage;
  logic [MAX_DEPTH:0][CTRL_W-1:0]   w_ctrl_taps;
  logic [CTRL_W-1:0]                w_ctrl_sel;
  logic [CTRL_W-1:0]                r_ctrl;

  assign w_ctrl_taps = {r_ctrl_stage, i_ctrl};

  dly_tap_sel #(.W(CTRL_W), .N(MAX_DEPTH + 1), .SEL_W(DLY_W)) u_ctrl_sel (
    .i_taps (w_ctrl_taps),
    .i_sel  (r_cur_dly),
    .o_word (w_ctrl_sel)
  );

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl_stage <= '0;
      r_ctrl       <= '0;
    end else if (i_flush) begin
      r_ctrl_stage <= '0;
      r_ctrl       <= '0;
    end else if (i_ce) begin
      r_ctrl_stage <= w_ctrl_taps[MAX_DEPTH-1:0];
      r_ctrl       <= w_ctrl_sel;
    end
  end

  assign o_ctrl = r_ctrl;
`endif

endmodule
